e_mdu: RTL and testbench

E_MDU -- requirements
Module: e_mdu

---
 rtl/e_mdu_pkg.sv | 35 +++
 rtl/e_mdu.sv | 116 +++++++++++
 tb/tb_e_mdu.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared multiply/divide definitions: E_MDOp encodings, latencies and FSM states.
// The hazard unit imports this package as well, so the codes and latencies are defined once.
package e_mdu_pkg;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    // E_MDOp encodings; 9-15 decode as "none"
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    // Cycles from the start edge until HI/LO hold the new result
    localparam logic [CNT_W-1:0] MUL_LAT = 4'd5;
    localparam logic [CNT_W-1:0] DIV_LAT = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    // True for every code the unit acts on (1-8)
    function automatic logic is_md_code(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MTLO);
    endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit. The result is computed in one step at the start edge
// into shadow registers, and then held back by a down-counter so that the architectural
// HI/LO registers change exactly MUL_LAT or DIV_LAT cycles later, like a multi-cycle unit.
module e_mdu
    import e_mdu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] E_RSData,
    input  logic [DATA_W-1:0] E_RTData,
    input  logic [3:0]        E_MDOp,
    output logic [DATA_W-1:0] E_MDData,
    output logic              E_Busy,
    output logic              E_MDStall
);

    md_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  hi_q, lo_q;
    logic [DATA_W-1:0]  hi_t_q, lo_t_q;

    logic [DATA_W-1:0]  hi_t_d, lo_t_d;
    logic [CNT_W-1:0]   cnt_d;
    logic               start;
    logic               sx;
    logic signed [63:0] mul_a, mul_b, mul_p;
    logic signed [32:0] dvd_s, dvs_s;

    assign start = (state_q == ST_IDLE) &&
                   (E_MDOp >= MD_MULT) && (E_MDOp <= MD_DIVU);

    // Single-step arithmetic for a start: shadow result and the counter load value
    always_comb begin
        sx     = (E_MDOp == MD_MULT) || (E_MDOp == MD_DIV);
        // Low 64 bits of the product of the extended operands are correct for
        // both signed and unsigned multiplies.
        mul_a  = {{32{sx & E_RSData[31]}}, E_RSData};
        mul_b  = {{32{sx & E_RTData[31]}}, E_RTData};
        mul_p  = mul_a * mul_b;
        // 33-bit signed division covers divu and keeps 0x80000000 / -1 well defined.
        // A zero divisor is replaced so the divider never sees it; its result is discarded.
        dvd_s  = {sx & E_RSData[31], E_RSData};
        dvs_s  = (E_RTData == '0) ? 33'sd1 : {sx & E_RTData[31], E_RTData};
        hi_t_d = hi_t_q;
        lo_t_d = lo_t_q;
        cnt_d  = cnt_q;
        case (E_MDOp)
            MD_MULT, MD_MULTU: begin
                hi_t_d = mul_p[63:32];
                lo_t_d = mul_p[31:0];
                cnt_d  = MUL_LAT;
            end
            MD_DIV, MD_DIVU: begin
                cnt_d = DIV_LAT;
                if (E_RTData == '0) begin
                    // Divide by zero still runs full length but commits the old values
                    hi_t_d = hi_q;
                    lo_t_d = lo_q;
                end else begin
                    hi_t_d = 32'(dvd_s % dvs_s);
                    lo_t_d = 32'(dvd_s / dvs_s);
                end
            end
            default: ;
        endcase
    end

    // Control FSM, shadow capture, latency counter and HI/LO updates
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_t_q  <= '0;
            lo_t_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        hi_t_q  <= hi_t_d;
                        lo_t_q  <= lo_t_d;
                        cnt_q   <= cnt_d;
                        state_q <= ST_BUSY;
                    end else if (E_MDOp == MD_MTHI) begin
                        hi_q <= E_RSData;
                    end else if (E_MDOp == MD_MTLO) begin
                        lo_q <= E_RSData;
                    end
                end
                ST_BUSY: begin
                    // Starts and moves to HI/LO are ignored here; the commit always wins
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        hi_q    <= hi_t_q;
                        lo_q    <= lo_t_q;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Read port and hazard outputs
    always_comb begin
        E_Busy    = (state_q == ST_BUSY);
        E_MDStall = is_md_code(E_MDOp) && (E_Busy || start);
        case (E_MDOp)
            MD_MFHI: E_MDData = hi_q;
            MD_MFLO: E_MDData = lo_q;
            default: E_MDData = '0;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: expected HI/LO values are queued when an operation is issued and
// popped when mfhi/mflo read the unit back; latency, busy and stall are checked inline.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic [31:0] E_RSData;
    logic [31:0] E_RTData;
    logic [3:0]  E_MDOp;
    logic [31:0] E_MDData;
    logic        E_Busy;
    logic        E_MDStall;

    int n_checks = 0;
    int n_err    = 0;
    logic [31:0] sb[$];
    logic [31:0] m_hi, m_lo;

    e_mdu dut (
        .clk       (clk),
        .reset     (reset),
        .E_RSData  (E_RSData),
        .E_RTData  (E_RTData),
        .E_MDOp    (E_MDOp),
        .E_MDData  (E_MDData),
        .E_Busy    (E_Busy),
        .E_MDStall (E_MDStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        E_MDOp   = op;
        E_RSData = rs;
        E_RTData = rt;
        #1;
    endtask

    task automatic push_hilo(input logic [31:0] hi, input logic [31:0] lo);
        sb.push_back(hi);
        sb.push_back(lo);
        m_hi = hi;
        m_lo = lo;
    endtask

    // mfhi then mflo, each popped against the scoreboard
    task automatic read_hilo(input string tag);
        logic [31:0] e;
        drive(4'd5, 32'h0, 32'h0);
        chk({tag, "_sb_hi"}, 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        chk({tag, "_hi"}, E_MDData, e);
        drive(4'd6, 32'h0, 32'h0);
        chk({tag, "_sb_lo"}, 32'(sb.size() > 0), 32'd1);
        e = (sb.size() > 0) ? sb.pop_front() : 32'h0;
        chk({tag, "_lo"}, E_MDData, e);
        drive(4'd0, 32'h0, 32'h0);
    endtask

    // Count cycles E_Busy stays high after the start edge, bounded
    task automatic wait_idle(input string tag, input int already, input int exp_cycles);
        int n;
        n = already;
        while (E_Busy && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_cycles));
    endtask

    task automatic run_md(input string tag, input logic [3:0] op,
                          input logic [31:0] rs, input logic [31:0] rt, input int exp_cycles);
        drive(op, rs, rt);
        chk({tag, "_stall_start"}, 32'(E_MDStall), 32'd1);
        tick();
        drive(4'd0, 32'h0, 32'h0);
        wait_idle(tag, 0, exp_cycles);
        read_hilo(tag);
    endtask

    // Independent reference for a start: pushes expected HI/LO and returns latency
    task automatic model_op(input logic [3:0] op, input logic [31:0] rs,
                            input logic [31:0] rt, output int lat);
        longint sa, sb_, q, r;
        logic [63:0] u;
        sa = longint'($signed(rs));
        sb_ = longint'($signed(rt));
        lat = 10;
        case (op)
            4'd1: begin
                q = sa * sb_;
                push_hilo(q[63:32], q[31:0]);
                lat = 5;
            end
            4'd2: begin
                u = {32'h0, rs} * {32'h0, rt};
                push_hilo(u[63:32], u[31:0]);
                lat = 5;
            end
            4'd3: begin
                if (rt == 32'h0) push_hilo(m_hi, m_lo);
                else begin
                    q = sa / sb_;
                    r = sa % sb_;
                    push_hilo(r[31:0], q[31:0]);
                end
            end
            default: begin
                if (rt == 32'h0) push_hilo(m_hi, m_lo);
                else push_hilo(rs % rt, rs / rt);
            end
        endcase
    endtask

    initial begin
        int lat;
        logic [3:0]  op;
        logic [31:0] a, b;

        m_hi = 32'h0;
        m_lo = 32'h0;
        reset = 1'b0;
        drive(4'd0, 32'h0, 32'h0);
        repeat (3) tick();
        chk("rst_busy_low", 32'(E_Busy), 32'd0);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(E_Busy), 32'd0);
        push_hilo(32'h0, 32'h0);
        read_hilo("rst");
        chk("idle_mfhi_stall", 32'(E_MDStall), 32'd0);

        // mult / multu with the same operands
        push_hilo(32'hFFFFFFFF, 32'hFFFFFFFE);
        run_md("mult", 4'd1, 32'hFFFFFFFF, 32'd2, 5);
        push_hilo(32'h00000001, 32'hFFFFFFFE);
        run_md("multu", 4'd2, 32'hFFFFFFFF, 32'd2, 5);

        // div / divu
        push_hilo(32'hFFFFFFFF, 32'hFFFFFFFD);
        run_md("div", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
        push_hilo(32'd1, 32'd3);
        run_md("divu", 4'd4, 32'd7, 32'd2, 10);

        // mthi/mtlo in idle, then divide by zero keeps them
        drive(4'd7, 32'h11, 32'h0);
        chk("mthi_idle_stall", 32'(E_MDStall), 32'd0);
        tick();
        drive(4'd8, 32'h22, 32'h0);
        tick();
        drive(4'd0, 32'h0, 32'h0);
        push_hilo(32'h11, 32'h22);
        read_hilo("mt");
        push_hilo(32'h11, 32'h22);
        run_md("divu0", 4'd4, 32'h1234, 32'h0, 10);

        // mthi during BUSY is ignored and stalls; op none does not stall
        push_hilo(32'h1, 32'h23450000);
        drive(4'd1, 32'h12345, 32'h10000);
        tick();
        drive(4'd7, 32'hABCD, 32'h0);
        chk("mthi_busy_stall", 32'(E_MDStall), 32'd1);
        tick();
        drive(4'd0, 32'h0, 32'h0);
        chk("none_busy_stall", 32'(E_MDStall), 32'd0);
        wait_idle("mult_mthi", 1, 5);
        read_hilo("mult_mthi");

        // Reserved codes change nothing
        drive(4'd12, 32'hDEAD, 32'hBEEF);
        chk("op12_stall", 32'(E_MDStall), 32'd0);
        chk("op12_data", E_MDData, 32'h0);
        tick();
        chk("op12_busy", 32'(E_Busy), 32'd0);
        drive(4'd0, 32'h0, 32'h0);
        push_hilo(m_hi, m_lo);
        read_hilo("op12");

        // Overflowing signed divide and a random mix through the model
        model_op(4'd3, 32'h80000000, 32'hFFFFFFFF, lat);
        run_md("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, lat);
        for (int i = 0; i < 8; i++) begin
            op = 4'($urandom_range(1, 4));
            a = $urandom;
            b = (i == 5) ? 32'h0 : $urandom;
            model_op(op, a, b, lat);
            run_md($sformatf("rnd%0d", i), op, a, b, lat);
        end

        // Reset pulsed in the third busy cycle of a mult: no late commit
        drive(4'd1, 32'h7, 32'h9);
        tick();
        drive(4'd0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(E_Busy), 32'd0);
        push_hilo(32'h0, 32'h0);
        read_hilo("rst_mid");
        reset = 1'b1;
        repeat (12) tick();
        chk("rst_after_busy", 32'(E_Busy), 32'd0);
        push_hilo(32'h0, 32'h0);
        read_hilo("rst_after");

        // First operation accepted on the first edge after release
        push_hilo(32'h0, 32'd42);
        run_md("post_rst", 4'd2, 32'd6, 32'd7, 5);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
